dmem_block_responder: RTL and testbench

Memory-side responder for the data-cache block interface. Accepts whole-block read (fill) and write (write-back) requests from the data-cache controller, models a fixed-latency backing store and answers with `memReadReady`/`memWriteDone`. It sits between the dcache controller and the (simulated) main memory and replaces ad-hoc bench stimulus on that interface.

---
 rtl/dmem_block_responder_pkg.sv | 19 +
 rtl/dmem_block_responder_if.sv | 37 +++
 rtl/dmem_block_array.sv | 47 ++++
 rtl/dmem_block_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_block_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_block_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_block_responder_pkg
// Description : Shared sizes and types for the data-memory block interface.
//               DMEM_BLOCK_ADDR_SIZE - width of a block address
//               DBLOCK_SIZE_BITS     - width of one cache block
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_block_responder_pkg;

  localparam int DMEM_BLOCK_ADDR_SIZE = 4;
  localparam int DBLOCK_SIZE_BITS     = 128;
  localparam int NUM_BLOCKS           = 1 << DMEM_BLOCK_ADDR_SIZE;

  typedef logic [DMEM_BLOCK_ADDR_SIZE-1:0] block_addr_t;
  typedef logic [DBLOCK_SIZE_BITS-1:0]     block_data_t;

endpackage
`default_nettype wire

// File: rtl/dmem_block_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_block_responder_if
// Description : Block request/response bundle between the dcache controller
//               (master) and the memory-side responder (slave).
//   memRen       master->slave  block read request, held until memReadReady
//   memWen       master->slave  block write request, held until memWriteDone
//   BlockAddr    master->slave  block address
//   memDin       master->slave  write-back block data
//   memReadReady slave->master  read data valid
//   memWriteDone slave->master  write committed
//   memDout      slave->master  registered read data
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_block_responder_if;
  import dmem_block_responder_pkg::*;

  logic        memRen;
  logic        memWen;
  block_addr_t BlockAddr;
  block_data_t memDin;
  logic        memReadReady;
  logic        memWriteDone;
  block_data_t memDout;

  modport master (
    output memRen, memWen, BlockAddr, memDin,
    input  memReadReady, memWriteDone, memDout
  );

  modport slave (
    input  memRen, memWen, BlockAddr, memDin,
    output memReadReady, memWriteDone, memDout
  );

endinterface
`default_nettype wire

// File: rtl/dmem_block_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_block_array
// Description : Single-port synchronous block RAM, one write port and a
//               registered read port. Contents start at zero and are not
//               touched by reset; only the read register is reset.
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset (read register only)
//   wr_en   in   store wr_data at addr on this edge
//   rd_en   in   load mem[addr] into rd_data on this edge
//   addr    in   block address
//   wr_data in   block to store
//   rd_data out  registered read block
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_block_array
  import dmem_block_responder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        rd_en,
  input  block_addr_t addr,
  input  block_data_t wr_data,
  output block_data_t rd_data
);

  // Declaration initialiser gives the power-on image; kept out of the reset
  // domain so a reset never wipes memory contents.
  block_data_t mem [NUM_BLOCKS] = '{default: '0};

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_block_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_block_responder
// Description : Memory-side responder for the dcache block interface. Accepts
//               whole-block fills and write-backs, models a fixed-latency
//               backing store and answers with memReadReady / memWriteDone.
//   clock  in     rising-edge clock
//   reset  in     asynchronous active-low reset
//   bus    slave  block request/response bundle
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_block_responder
  import dmem_block_responder_pkg::*;
#(
  parameter int READ_LATENCY  = 10,
  parameter int WRITE_LATENCY = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  dmem_block_responder_if.slave   bus
);

  localparam int CNT_W = 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WRITE_WAIT = 3'd1;
  localparam logic [2:0] ST_WRITE_DONE = 3'd2;
  localparam logic [2:0] ST_READ_WAIT  = 3'd3;
  localparam logic [2:0] ST_READ_DONE  = 3'd4;

  // Loading LATENCY-1 and moving on at zero puts completion exactly LATENCY
  // edges after the acceptance edge.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] cnt;
  block_addr_t      addr_q;
  block_data_t      data_q;
  logic             arr_wr_en;
  logic             arr_rd_en;
  block_data_t      arr_rd_data;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        // Write has priority; a concurrently held read is picked up after
        // the write transaction has been released.
        if (bus.memWen) begin
          next_state = ST_WRITE_WAIT;
        end else if (bus.memRen) begin
          next_state = ST_READ_WAIT;
        end
      end
      ST_WRITE_WAIT: begin
        if (!bus.memWen) begin
          next_state = ST_IDLE;
        end else if (cnt == '0) begin
          next_state = ST_WRITE_DONE;
        end
      end
      ST_WRITE_DONE: begin
        if (!bus.memWen) begin
          next_state = ST_IDLE;
        end
      end
      ST_READ_WAIT: begin
        if (!bus.memRen) begin
          next_state = ST_IDLE;
        end else if (cnt == '0) begin
          next_state = ST_READ_DONE;
        end
      end
      ST_READ_DONE: begin
        if (!bus.memRen) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    bus.memReadReady = (state == ST_READ_DONE);
    bus.memWriteDone = (state == ST_WRITE_DONE);
    // Array access only on the completing edge of a request still held, so
    // an abort leaves both memory and memDout untouched.
    arr_wr_en = (state == ST_WRITE_WAIT) && bus.memWen && (cnt == '0);
    arr_rd_en = (state == ST_READ_WAIT)  && bus.memRen && (cnt == '0);
  end

  assign bus.memDout = arr_rd_data;

  // ------------------------------------------- counter and request capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.memWen) begin
            cnt    <= WR_LOAD;
            addr_q <= bus.BlockAddr;
            data_q <= bus.memDin;
          end else if (bus.memRen) begin
            cnt    <= RD_LOAD;
            addr_q <= bus.BlockAddr;
          end
        end
        ST_WRITE_WAIT, ST_READ_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // --------------------------------------------------------- backing store
  dmem_block_array u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (arr_wr_en),
    .rd_en   (arr_rd_en),
    .addr    (addr_q),
    .wr_data (data_q),
    .rd_data (arr_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_block_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_block_responder
// Description : Directed self-checking bench for dmem_block_responder.
//               dut_a uses default latencies (10/10), dut_b uses 1/1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_block_responder;
  import dmem_block_responder_pkg::*;

  logic clock;
  logic reset;

  int n_checks;
  int n_fails;

  dmem_block_responder_if bus_a ();
  dmem_block_responder_if bus_b ();

  dmem_block_responder dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  dmem_block_responder #(
    .READ_LATENCY  (1),
    .WRITE_LATENCY (1)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic read_a(input block_addr_t addr, input block_data_t exp,
                        input string tag);
    bus_a.BlockAddr = addr;
    bus_a.memRen    = 1'b1;
    step(1);                       // acceptance edge
    step(9);
    check_val({tag, "_rdy_early"}, 128'(bus_a.memReadReady), 128'd0);
    step(1);
    check_val({tag, "_rdy"}, 128'(bus_a.memReadReady), 128'd1);
    check_val({tag, "_dout"}, bus_a.memDout, exp);
    bus_a.memRen = 1'b0;
    step(1);
    check_val({tag, "_rdy_fall"}, 128'(bus_a.memReadReady), 128'd0);
  endtask

  task automatic write_a(input block_addr_t addr, input block_data_t data,
                         input string tag);
    bus_a.BlockAddr = addr;
    bus_a.memDin    = data;
    bus_a.memWen    = 1'b1;
    step(1);
    step(9);
    check_val({tag, "_done_early"}, 128'(bus_a.memWriteDone), 128'd0);
    step(1);
    check_val({tag, "_done"}, 128'(bus_a.memWriteDone), 128'd1);
    bus_a.memWen = 1'b0;
    step(1);
    check_val({tag, "_done_fall"}, 128'(bus_a.memWriteDone), 128'd0);
  endtask

  localparam block_data_t D_AA   = {8'hAA, 120'h0};
  localparam block_data_t D_ONES = '1;
  localparam block_data_t D_1    = 128'h0111_2222_3333_4444_5555_6666_7777_8888;
  localparam block_data_t D_2    = 128'h0222_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111;
  localparam block_data_t D_B    = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b0;
    bus_a.memRen = 1'b0; bus_a.memWen = 1'b0; bus_a.BlockAddr = '0; bus_a.memDin = '0;
    bus_b.memRen = 1'b0; bus_b.memWen = 1'b0; bus_b.BlockAddr = '0; bus_b.memDin = '0;
    step(2);
    check_val("rst_rdy",   128'(bus_a.memReadReady), 128'd0);
    check_val("rst_done",  128'(bus_a.memWriteDone), 128'd0);
    check_val("rst_dout",  bus_a.memDout, 128'd0);
    check_val("rst_state", 128'(dut_a.state), 128'd0);
    check_val("rst_cnt",   128'(dut_a.cnt), 128'd0);
    reset = 1'b1;
    step(1);

    // Reset asserted mid READ_WAIT
    bus_a.BlockAddr = 4'h3;
    bus_a.memRen    = 1'b1;
    step(1);
    step(4);
    reset = 1'b0;
    #1;
    check_val("midrst_state", 128'(dut_a.state), 128'd0);
    check_val("midrst_rdy",   128'(bus_a.memReadReady), 128'd0);
    bus_a.memRen = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    read_a(4'h3, 128'd0, "rd3");

    // Write then read back
    write_a(4'h9, D_AA, "wr9");
    read_a(4'h9, D_AA, "rd9");

    // Simultaneous request: write first, then the held read
    bus_a.BlockAddr = 4'hA;
    bus_a.memDin    = D_ONES;
    bus_a.memWen    = 1'b1;
    bus_a.memRen    = 1'b1;
    step(1);
    step(10);
    check_val("both_done", 128'(bus_a.memWriteDone), 128'd1);
    check_val("both_rdy0", 128'(bus_a.memReadReady), 128'd0);
    bus_a.memWen = 1'b0;
    step(1);
    check_val("both_done_fall", 128'(bus_a.memWriteDone), 128'd0);
    step(1);                       // read accepted here
    step(9);
    check_val("both_rdy_early", 128'(bus_a.memReadReady), 128'd0);
    step(1);
    check_val("both_rdy",  128'(bus_a.memReadReady), 128'd1);
    check_val("both_dout", bus_a.memDout, D_ONES);
    bus_a.memRen = 1'b0;
    step(1);

    // Aborted read of 0x5
    bus_a.BlockAddr = 4'h5;
    bus_a.memRen    = 1'b1;
    step(1);
    step(4);
    bus_a.memRen = 1'b0;
    step(1);
    check_val("ab_rd_state", 128'(dut_a.state), 128'd0);
    step(10);
    check_val("ab_rd_rdy",  128'(bus_a.memReadReady), 128'd0);
    check_val("ab_rd_dout", bus_a.memDout, D_ONES);

    // Aborted write of 0x5 must leave the block at zero
    bus_a.BlockAddr = 4'h5;
    bus_a.memDin    = 128'h1234;
    bus_a.memWen    = 1'b1;
    step(1);
    step(3);
    bus_a.memWen = 1'b0;
    step(1);
    check_val("ab_wr_state", 128'(dut_a.state), 128'd0);
    step(12);
    check_val("ab_wr_done", 128'(bus_a.memWriteDone), 128'd0);
    read_a(4'h5, 128'd0, "rd5");

    // Address change after acceptance is ignored
    write_a(4'h1, D_1, "wr1");
    write_a(4'h2, D_2, "wr2");
    bus_a.BlockAddr = 4'h1;
    bus_a.memRen    = 1'b1;
    step(1);
    bus_a.BlockAddr = 4'h2;
    step(9);
    check_val("achg_rdy_early", 128'(bus_a.memReadReady), 128'd0);
    step(1);
    check_val("achg_rdy",  128'(bus_a.memReadReady), 128'd1);
    check_val("achg_dout", bus_a.memDout, D_1);
    bus_a.memRen = 1'b0;
    step(1);

    // Latency 1, back-to-back write then read
    bus_b.BlockAddr = 4'h4;
    bus_b.memDin    = D_B;
    bus_b.memWen    = 1'b1;
    step(1);                       // accept
    check_val("l1_done0", 128'(bus_b.memWriteDone), 128'd0);
    step(1);
    check_val("l1_done1", 128'(bus_b.memWriteDone), 128'd1);
    bus_b.memWen = 1'b0;
    bus_b.memRen = 1'b1;
    step(1);                       // release edge -> IDLE
    check_val("l1_done_fall", 128'(bus_b.memWriteDone), 128'd0);
    check_val("l1_idle",      128'(dut_b.state), 128'd0);
    step(1);                       // read accept
    check_val("l1_rdy0", 128'(bus_b.memReadReady), 128'd0);
    step(1);
    check_val("l1_rdy1", 128'(bus_b.memReadReady), 128'd1);
    check_val("l1_dout", bus_b.memDout, D_B);
    bus_b.memRen = 1'b0;
    step(1);
    check_val("l1_rdy_fall", 128'(bus_b.memReadReady), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
